// File: rtl/restoring_divider_pkg.sv
// Shared constants for the radix-2 restoring divider: FSM encodings,
// counter sizing and the divide-by-zero quotient pattern.
package restoring_divider_pkg;

    localparam int DIV_N = 8;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

    // Wide all-ones pattern; users slice it down to their operand width.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/restoring_divider_trial_subtractor.sv
// Combinational trial subtraction with borrow-out, shared with the sqrt unit.
module trial_subtractor #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_minuend,
    input  logic [W-1:0] i_subtrahend,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    assign {o_borrow, o_diff} = {1'b0, i_minuend} - {1'b0, i_subtrahend};

endmodule

// File: rtl/restoring_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, with
// valid/ready on both sides. Define RESTORING_DIVIDER_SIGNED_EN for
// two's-complement operands (truncating division).
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(N);

    state_t        r_state;
    logic [N-1:0]  r_div;
    logic [N-1:0]  r_quo;
    logic [N:0]    r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;
    logic          r_out_valid;

    logic [N-1:0]  w_dividend_mag;
    logic [N-1:0]  w_divisor_mag;
    logic [2*N:0]  w_shift;
    logic [N:0]    w_diff;
    logic          w_borrow;
    logic [N:0]    w_step_rem;
    logic [N-1:0]  w_step_quo;
    logic [N-1:0]  w_fin_quo;
    logic [N-1:0]  w_fin_rem;

`ifdef RESTORING_DIVIDER_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_dividend_mag = dividend[N-1] ? -dividend : dividend;
    assign w_divisor_mag  = divisor[N-1]  ? -divisor  : divisor;
    assign w_fin_quo      = r_neg_q ? -w_step_quo : w_step_quo;
    assign w_fin_rem      = r_neg_r ? -w_step_rem[N-1:0] : w_step_rem[N-1:0];
`else
    assign w_dividend_mag = dividend;
    assign w_divisor_mag  = divisor;
    assign w_fin_quo      = w_step_quo;
    assign w_fin_rem      = w_step_rem[N-1:0];
`endif

    // Bit 0 of the shifted quotient is always zero, so OR-ing in the new bit is safe.
    assign w_shift    = {r_rem, r_quo} << 1;
    assign w_step_rem = w_borrow ? w_shift[2*N:N] : w_diff;
    assign w_step_quo = w_shift[N-1:0] | {{(N-1){1'b0}}, ~w_borrow};

    trial_subtractor #(.W(N + 1)) u_trial (
        .i_minuend    (w_shift[2*N:N]),
        .i_subtrahend ({1'b0, r_div}),
        .o_diff       (w_diff),
        .o_borrow     (w_borrow)
    );

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would chain the shift within one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_div <= w_divisor_mag;
                        r_cnt <= CW'(N - 1);
`ifdef RESTORING_DIVIDER_SIGNED_EN
                        r_neg_q <= dividend[N-1] ^ divisor[N-1];
                        r_neg_r <= dividend[N-1];
`endif
                        if (divisor == '0) begin
                            r_quo   <= DBZ_QUOTIENT[N-1:0];
                            r_rem   <= {1'b0, dividend};
                            r_dbz   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_quo   <= w_dividend_mag;
                            r_rem   <= '0;
                            r_dbz   <= 1'b0;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_quo   <= w_fin_quo;
                        r_rem   <= {1'b0, w_fin_rem};
                        r_state <= DONE;
                    end else begin
                        r_quo <= w_step_quo;
                        r_rem <= w_step_rem;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Result registers settle on entry; out_valid rises one cycle later.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quo;
    assign remainder   = r_rem[N-1:0];
    assign div_by_zero = r_dbz;

endmodule
